mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter and sequencer for the single-ported unified memory shared by the pipeline's instruction fetch (IF) and data memory (MEM) stages. It grants one requester at a time and holds the granted address and control for a fixed number of wait cycles. It then returns read data to that requester with a one-cycle ready pulse. The pipeline holds the requesting stage frozen while its request is high and its ready is low.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `WAIT_CYCLES`, default 2: cycles that `ram_en` is held per access. Legal range is 1..15.

- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `if_req` in 1: fetch request. Held high until `if_ready` is seen.
- `if_addr` in ADDR_W: fetch address.
- `if_flush` in 1: taken branch; discards the in-flight or just-granted fetch.
- `if_rdata` out DATA_W: fetched instruction. Valid when `if_ready` is high.
- `if_ready` out 1: one-cycle completion pulse for a fetch.
- `mem_req` in 1: data request, MemRead or MemWrite. Held until `mem_ready` is seen.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_addr` in ADDR_W: data address.
- `mem_wdata` in DATA_W: store data.
- `mem_rdata` out DATA_W: load data. Valid when `mem_ready` is high.
- `mem_ready` out 1: one-cycle completion pulse for a data access.
- `ram_en` out 1: memory enable.
- `ram_we` out 1: memory write enable.
- `ram_addr` out ADDR_W: memory address.
- `ram_wdata` out DATA_W: memory write data.
- `ram_rdata` in DATA_W: memory read data. Valid in the last enabled cycle.

## Operation
**States**
- IDLE, BUSY_IF, BUSY_MEM.
- One 4-bit wait counter `cnt`.
- One drop flag.
- Latched registers: `addr`, `we`, `wdata`.

**Grant in IDLE**
- Priority: `mem_req` first, then `if_req`.
- A requester whose ready is high this cycle is masked for the grant. Its request is stale.
- With both requesters continuously active, grants therefore alternate MEM, IF, MEM, …
- On grant:
  - latch the address, plus `we`/`wdata` for MEM (`we` = 0 for IF);
  - set `cnt` to 0;
  - move to BUSY_MEM or BUSY_IF.

**BUSY_x**
- `ram_en` = 1.
- `ram_we` = latched `we`.
- `ram_addr` and `ram_wdata` driven from the latched registers.
- `cnt` increments each cycle.
- When `cnt == WAIT_CYCLES-1`:
  - a load or fetch captures `ram_rdata` into the requester's rdata register;
  - the requester's ready is set for the next cycle;
  - state returns to IDLE.

**Stores**
- `mem_ready` pulses.
- `mem_rdata` keeps its previous value.

**Flush**
- `if_flush` high while in BUSY_IF, or in the IDLE cycle that grants IF, sets the drop flag.
- The access still runs its full `WAIT_CYCLES`, because the memory is not aborted.
- At completion:
  - `if_ready` is suppressed;
  - `if_rdata` is not updated;
  - the drop flag is cleared.
- `if_flush` has no effect on MEM accesses or in BUSY_MEM.
- `if_flush` in IDLE with no IF grant has no effect.

**Outputs when not busy**
- `ram_en` = `ram_we` = 0.
- `ram_addr` and `ram_wdata` hold their last values.

**Unrelated inputs**
- Inputs that change while the other requester is busy are ignored.

## Timing
**Reset**
- `rst_n` low asynchronously forces:
  - state IDLE, `cnt` 0, drop flag 0;
  - `if_ready`, `mem_ready`, `ram_en`, `ram_we` = 0;
  - `if_rdata`, `mem_rdata`, `ram_addr`, `ram_wdata` = 0.
- Reset mid-access aborts the access. No ready pulse is produced after reset is released.

**Latency and throughput**
- A request seen in IDLE at cycle T gives `ram_en` high in cycles T+1 .. T+WAIT_CYCLES.
- Ready pulses in cycle T+WAIT_CYCLES+1, together with valid rdata.
- The arbiter returns to IDLE in that same cycle T+WAIT_CYCLES+1 and may grant again.
- Peak rate: one access per WAIT_CYCLES+1 cycles.

**Handshake rules**
- A requester drops or replaces its request on the edge after its ready pulse.
- Ready is exactly one cycle wide. It is never asserted for the non-granted requester.
- `if_ready` and `mem_ready` are never high in the same cycle.

**Simultaneous events**
- `mem_req` and `if_req` arriving in the same IDLE cycle: MEM wins.
- `if_flush` in the same cycle as `if_ready`: no effect on that pulse, which is already committed.

## Test plan
1. **Fetch only, WAIT_CYCLES = 2.** Drive `if_req`=1, `if_addr`=0x10 at cycle 1; `ram_rdata`=0x00500093 in cycle 3.
   - Expect `ram_en`=1 with `ram_addr`=0x10 in cycles 2–3.
   - Expect `if_ready`=1 and `if_rdata`=0x00500093 in cycle 4 only.
2. **Simultaneous requests.** Assert `mem_req` (load, 0x200) and `if_req` (0x14) together at cycle T.
   - Expect MEM granted first and `mem_ready` at T+3.
   - Expect IF granted at T+3 and `if_ready` at T+6. No overlap of `ram_en` accesses.
3. **Store.** Drive `mem_we`=1, `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF.
   - Expect `ram_we`=`ram_en`=1 for 2 cycles with `ram_wdata`=0xDEADBEEF.
   - Expect a `mem_ready` pulse, with `mem_rdata` unchanged from its prior value.
4. **Continuous contention.** Hold both requests high for 12 cycles.
   - Expect grants in the order MEM, IF, MEM, IF.
   - Expect ready pulses at 3-cycle spacing, alternating requester.
5. **Flush.** Pulse `if_flush` during the first BUSY_IF cycle of a fetch to 0x20.
   - Expect the access to run its full 2 cycles with no `if_ready` and `if_rdata` unchanged.
   - The next `if_req` (0x40) completes normally.
6. **Reset mid-access.** Pull `rst_n` low in the second BUSY_MEM cycle.
   - Expect all outputs 0 immediately.
   - After release with no requests, expect no `mem_ready` and state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the unified single-ported memory shared by fetch (IF) and data (MEM).
// One access at a time, held WAIT_CYCLES cycles, completed by a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyMem} state_e;

  localparam logic [3:0] CntLast = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              drop_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic              if_ready_q, mem_ready_q;

  logic grant_mem, grant_if, last;

  // A requester whose ready pulse is showing still has its stale request up; mask it.
  assign grant_mem = mem_req & ~mem_ready_q;
  assign grant_if  = ~grant_mem & if_req & ~if_ready_q;
  assign last      = (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_mem) begin
          state_d = StBusyMem;
        end else if (grant_if) begin
          state_d = StBusyIf;
        end
      end
      StBusyIf, StBusyMem: begin
        if (last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ram_en = 1'b0;
    ram_we = 1'b0;
    if (state_q != StIdle) begin
      ram_en = 1'b1;
      ram_we = we_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (grant_mem) begin
            addr_q  <= mem_addr;
            we_q    <= mem_we;
            wdata_q <= mem_wdata;
          end else if (grant_if) begin
            addr_q <= if_addr;
            we_q   <= 1'b0;
            drop_q <= if_flush;
          end
        end
        StBusyIf: begin
          cnt_q <= cnt_q + 4'd1;
          if (last) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
            // The memory access always runs to completion; a flush only hides its result.
            if (!(drop_q | if_flush)) begin
              if_rdata_q <= ram_rdata;
              if_ready_q <= 1'b1;
            end
          end else if (if_flush) begin
            drop_q <= 1'b1;
          end
        end
        StBusyMem: begin
          cnt_q <= cnt_q + 4'd1;
          if (last) begin
            cnt_q       <= '0;
            mem_ready_q <= 1'b1;
            if (!we_q) mem_rdata_q <= ram_rdata;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule
